// File: rtl/priority_index_decoder_sequencer.sv
// Generic FIFO: registered count, push gated by push_rdy, pop ignored when empty.
// Read data is the current head (combinational); push_rdy depends only on the registered count.
module pids_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  output logic                       push_rdy,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign push_rdy = (count != DEPTH_C);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && (count != '0);
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Replays buffered encoder indices as one-hot pulses of HOLD_CYCLES cycles plus a one-cycle gap.
// First pulse appears one edge after the push into an idle block; in_ready drops only when the FIFO is full.
module priority_index_decoder_sequencer #(
  parameter int IDX_W       = 2,
  parameter int OUT_W       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IDX_W-1:0]              in_idx,
  input  logic                          in_none,
  output logic [OUT_W-1:0]              out_onehot,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH)+1-1:0] fifo_count,
  output logic                          busy
);
  localparam int HC_W = $clog2(HOLD_CYCLES+1);
  localparam logic [HC_W-1:0] HOLD_LD = HC_W'(HOLD_CYCLES-1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t            state, state_nxt;
  logic [HC_W-1:0]   hold_cnt, hold_nxt;
  logic [OUT_W-1:0]  onehot_nxt;
  logic              valid_nxt;
  logic              pop_vld;
  logic              load;
  logic              clear;
  logic [IDX_W:0]    head_dat;
  logic [IDX_W-1:0]  head_idx;
  logic              head_none;

  // $clog2(D)+1 equals $clog2(D+1) for power-of-two depths.
  pids_fifo #(.W(IDX_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat ({in_none, in_idx}),
    .pop_vld  (pop_vld),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

  assign head_idx  = head_dat[IDX_W-1:0];
  assign head_none = head_dat[IDX_W];
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      out_onehot <= onehot_nxt;
      out_valid  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pop_vld   = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (fifo_count != '0) begin
          pop_vld   = 1'b1;
          load      = 1'b1;
          hold_nxt  = HOLD_LD;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - 1'b1;
        end else begin
          clear     = 1'b1;
          state_nxt = GAP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    onehot_nxt = out_onehot;
    valid_nxt  = out_valid;
    if (load) begin
      onehot_nxt = head_none ? '0 : (OUT_W'(1) << head_idx);
      valid_nxt  = 1'b1;
    end else if (clear) begin
      onehot_nxt = '0;
      valid_nxt  = 1'b0;
    end
  end
endmodule
